// File: rtl/lbist_sequencer_if.sv
// Scan/control bundle between the LBIST sequencer and the scan-inserted core wrapper.
// master = sequencer side, slave = core/wrapper side.
interface lbist_sequencer_if #(
    parameter int unsigned NUM_CHAINS = 20,
    parameter int unsigned PCNT_W     = 11
);
    logic                  start_i;
    logic                  scan_en_o;
    logic                  test_mode_o;
    logic [NUM_CHAINS-1:0] scan_in_o;
    logic [NUM_CHAINS-1:0] scan_out_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  pass_o;
    logic [31:0]           signature_o;
    logic [PCNT_W-1:0]     pattern_cnt_o;

    modport master (
        input  start_i,
        input  scan_out_i,
        output scan_en_o,
        output test_mode_o,
        output scan_in_o,
        output busy_o,
        output done_o,
        output pass_o,
        output signature_o,
        output pattern_cnt_o
    );

    modport slave (
        output start_i,
        output scan_out_i,
        input  scan_en_o,
        input  test_mode_o,
        input  scan_in_o,
        input  busy_o,
        input  done_o,
        input  pass_o,
        input  signature_o,
        input  pattern_cnt_o
    );
endinterface

// File: rtl/lbist_sequencer.sv
// Logic-BIST controller: LFSR scan stimulus, shift/capture sequencing,
// MISR compaction of chain outputs and golden-signature verdict.
module lbist_sequencer #(
    parameter int unsigned NUM_CHAINS   = 20,
    parameter int unsigned CHAIN_LEN    = 64,
    parameter int unsigned NUM_PATTERNS = 1024,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
    parameter logic [31:0] MISR_GOLDEN  = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    lbist_sequencer_if.master   bus
);

    localparam int unsigned PCNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned SH_W      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [31:0] MISR_POLY = 32'h0040_0007;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_UNLOAD  = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [SH_W-1:0]   SH_LAST  = SH_W'(CHAIN_LEN - 1);
    localparam logic [PCNT_W-1:0] PCNT_END = PCNT_W'(NUM_PATTERNS);

    logic [2:0]        state_q,     state_d;
    logic [31:0]       lfsr_q,      lfsr_d;
    logic [31:0]       misr_q,      misr_d;
    logic [SH_W-1:0]   shcnt_q,     shcnt_d;
    logic [PCNT_W-1:0] pcnt_q,      pcnt_d;
    logic              pass_q,      pass_d;
    logic              scan_en_q,   scan_en_d;
    logic              test_mode_q, test_mode_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic [31:0]       lfsr_next;
    logic [31:0]       misr_next;
    logic [PCNT_W-1:0] pcnt_inc;

    // Fibonacci LFSR x^32+x^22+x^2+x+1, shifting left
    assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    assign misr_next = {misr_q[30:0], 1'b0}
                     ^ (misr_q[31] ? MISR_POLY : 32'h0000_0000)
                     ^ 32'(bus.scan_out_i);

    assign pcnt_inc = PCNT_W'(pcnt_q + PCNT_W'(1));

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        shcnt_d = shcnt_q;
        pcnt_d  = pcnt_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    pass_d  = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                lfsr_d  = LFSR_SEED;
                misr_d  = 32'h0000_0000;
                shcnt_d = '0;
                pcnt_d  = '0;
                pass_d  = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                lfsr_d = lfsr_next;
                // Chain contents before the first capture are unknown: keep them out of the MISR
                if (pcnt_q != '0) begin
                    misr_d = misr_next;
                end
                if (shcnt_q == SH_LAST) begin
                    shcnt_d = '0;
                    state_d = S_CAPTURE;
                end else begin
                    shcnt_d = SH_W'(shcnt_q + SH_W'(1));
                end
            end
            S_CAPTURE: begin
                pcnt_d = pcnt_inc;
                if (pcnt_inc == PCNT_END) begin
                    state_d = S_UNLOAD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_UNLOAD: begin
                lfsr_d = lfsr_next;
                misr_d = misr_next;
                if (shcnt_q == SH_LAST) begin
                    shcnt_d = '0;
                    state_d = S_COMPARE;
                end else begin
                    shcnt_d = SH_W'(shcnt_q + SH_W'(1));
                end
            end
            S_COMPARE: begin
                pass_d  = (misr_q == MISR_GOLDEN);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start_i) begin
                    pass_d  = 1'b0;
                    state_d = S_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q
    always_comb begin
        scan_en_d   = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        test_mode_d = busy_d;
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q      <= LFSR_SEED;
            misr_q      <= 32'h0000_0000;
            shcnt_q     <= '0;
            pcnt_q      <= '0;
            pass_q      <= 1'b0;
            scan_en_q   <= 1'b0;
            test_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            misr_q      <= misr_d;
            shcnt_q     <= shcnt_d;
            pcnt_q      <= pcnt_d;
            pass_q      <= pass_d;
            scan_en_q   <= scan_en_d;
            test_mode_q <= test_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Stimulus is only driven while shifting so the pins idle at 0 outside a run
    assign bus.scan_in_o     = (state_q == S_SHIFT) ? lfsr_q[NUM_CHAINS-1:0] : '0;
    assign bus.scan_en_o     = scan_en_q;
    assign bus.test_mode_o   = test_mode_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.pass_o        = pass_q;
    assign bus.signature_o   = misr_q;
    assign bus.pattern_cnt_o = pcnt_q;

endmodule

// File: tb/tb_lbist_sequencer.sv
// Directed bench for lbist_sequencer with CHAIN_LEN=4, NUM_PATTERNS=2, 20 chains.
module tb_lbist_sequencer;

    localparam int unsigned NC     = 20;
    localparam int unsigned CL     = 4;
    localparam int unsigned NP     = 2;
    localparam int unsigned PCNT_W = $clog2(NP + 1);

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lbist_sequencer_if #(.NUM_CHAINS(NC), .PCNT_W(PCNT_W)) bus ();

    lbist_sequencer #(
        .NUM_CHAINS  (NC),
        .CHAIN_LEN   (CL),
        .NUM_PATTERNS(NP),
        .LFSR_SEED   (32'h0000_0001),
        .MISR_GOLDEN (32'h0000_0000)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Moore decode of the cycle map for a run started at cycle 0
    function automatic logic exp_scan_en(input int c);
        return (c >= 2) && (c <= 15) && (c != 6) && (c != 11);
    endfunction

    task automatic start_pulse();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".scan_en"},   32'(bus.scan_en_o),     32'h0);
        check({tag, ".test_mode"}, 32'(bus.test_mode_o),   32'h0);
        check({tag, ".scan_in"},   32'(bus.scan_in_o),     32'h0);
        check({tag, ".busy"},      32'(bus.busy_o),        32'h0);
        check({tag, ".done"},      32'(bus.done_o),        32'h0);
        check({tag, ".pass"},      32'(bus.pass_o),        32'h0);
        check({tag, ".sig"},       bus.signature_o,        32'h0);
        check({tag, ".pcnt"},      32'(bus.pattern_cnt_o), 32'h0);
    endtask

    logic [31:0] lfsr_tab [0:4];

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.scan_out_i = '0;
        lfsr_tab[0] = 32'h1;  lfsr_tab[1] = 32'h3;  lfsr_tab[2] = 32'h6;
        lfsr_tab[3] = 32'hD;  lfsr_tab[4] = 32'h1B;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("idle.done", 32'(bus.done_o), 32'h0);

        // Run A: scan_out=0, timing and LFSR stimulus
        start_pulse();
        check("A.c1.busy",      32'(bus.busy_o),      32'h1);
        check("A.c1.test_mode", 32'(bus.test_mode_o), 32'h1);
        check("A.c1.scan_en",   32'(bus.scan_en_o),   32'h0);
        check("A.c1.done",      32'(bus.done_o),      32'h0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            check($sformatf("A.c%0d.scan_en", c), 32'(bus.scan_en_o), 32'(exp_scan_en(c)));
            check($sformatf("A.c%0d.done", c),    32'(bus.done_o),    32'h0);
            if (c >= 2 && c <= 5)
                check($sformatf("A.c%0d.scan_in", c), 32'(bus.scan_in_o), lfsr_tab[c-2]);
            if (c == 7) begin
                check("A.c7.scan_in", 32'(bus.scan_in_o),     lfsr_tab[4]);
                check("A.c7.pcnt",    32'(bus.pattern_cnt_o), 32'h1);
            end
            if (c == 12) begin
                check("A.c12.pcnt", 32'(bus.pattern_cnt_o), 32'h2);
                check("A.c12.busy", 32'(bus.busy_o),        32'h1);
            end
        end
        tick();
        check("A.c17.done",      32'(bus.done_o),        32'h1);
        check("A.c17.busy",      32'(bus.busy_o),        32'h0);
        check("A.c17.test_mode", 32'(bus.test_mode_o),   32'h0);
        check("A.c17.scan_en",   32'(bus.scan_en_o),     32'h0);
        check("A.c17.sig",       bus.signature_o,        32'h0);
        check("A.c17.pass",      32'(bus.pass_o),        32'h1);
        check("A.c17.pcnt",      32'(bus.pattern_cnt_o), 32'h2);
        tick();
        check("A.hold.done", 32'(bus.done_o), 32'h1);
        check("A.hold.pass", 32'(bus.pass_o), 32'h1);

        // Run B: restart from DONE, scan_out=1, stray start at cycle 8
        bus.scan_out_i = 20'h00001;
        start_pulse();
        check("B.c1.done", 32'(bus.done_o), 32'h0);
        check("B.c1.pass", 32'(bus.pass_o), 32'h0);
        check("B.c1.busy", 32'(bus.busy_o), 32'h1);
        for (int c = 2; c <= 16; c++) begin
            tick();
            bus.start_i = 1'b0;
            check($sformatf("B.c%0d.scan_en", c), 32'(bus.scan_en_o), 32'(exp_scan_en(c)));
            if (c <= 7)
                check($sformatf("B.c%0d.sig", c), bus.signature_o, 32'h0);
            if (c == 8)  check("B.c8.sig",  bus.signature_o, 32'h1);
            if (c == 12) check("B.c12.sig", bus.signature_o, 32'hF);
            if (c == 8)  bus.start_i = 1'b1;
        end
        tick();
        check("B.c17.done", 32'(bus.done_o),        32'h1);
        check("B.c17.sig",  bus.signature_o,        32'h0000_00FF);
        check("B.c17.pass", 32'(bus.pass_o),        32'h0);
        check("B.c17.pcnt", 32'(bus.pattern_cnt_o), 32'h2);

        // Run C: reset at cycle 9 aborts, then a fresh run reproduces run B
        start_pulse();
        for (int c = 2; c <= 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("C.c10");
        tick();
        tick();
        check("C.idle.done", 32'(bus.done_o), 32'h0);
        check("C.idle.busy", 32'(bus.busy_o), 32'h0);
        start_pulse();
        for (int c = 2; c <= 16; c++) tick();
        check("C.c16.done", 32'(bus.done_o), 32'h0);
        tick();
        check("C.c17.done", 32'(bus.done_o),  32'h1);
        check("C.c17.sig",  bus.signature_o,  32'h0000_00FF);
        check("C.c17.pass", 32'(bus.pass_o),  32'h0);

        // Run D: all chains return 1
        bus.scan_out_i = 20'hFFFFF;
        start_pulse();
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (c == 12) check("D.c12.sig", bus.signature_o, 32'h0050_0005);
        end
        tick();
        check("D.c17.done", 32'(bus.done_o), 32'h1);
        check("D.c17.sig",  bus.signature_o, 32'h0550_0055);
        check("D.c17.pass", 32'(bus.pass_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
